// File: rtl/sobol_multi_gen.sv
// Multi-dimensional Sobol point generator: DIMS coordinates of WIDTH bits per point,
// stepped in Gray-code order by XOR with the direction vector at the lowest zero bit of the index.
module sobol_multi_gen #(
    parameter int WIDTH = 6,
    parameter int DIMS  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DIMS*WIDTH*WIDTH-1:0] v_in,
    input  logic                        en_in,
    input  logic                        start,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [DIMS*WIDTH-1:0]       out_data,
    output logic [WIDTH-1:0]            out_index,
    output logic                        out_last,
    output logic                        busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t                      state, state_n;
    logic [DIMS*WIDTH*WIDTH-1:0] vec, vec_n;
    logic [DIMS*WIDTH-1:0]       data_n, step;
    logic [WIDTH-1:0]            index_n;
    logic                        valid_n;
    logic [CW-1:0]               lz;

    // Lowest zero bit of the current index; scanning MSB down lets the lowest hit win.
    always_comb begin
        lz = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (!out_index[k]) lz = CW'(k);
        end
    end

    always_comb begin
        step = '0;
        for (int d = 0; d < DIMS; d++) begin
            step[d*WIDTH +: WIDTH] = vec[(d*WIDTH + int'(lz))*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        state_n = state;
        vec_n   = vec;
        data_n  = out_data;
        index_n = out_index;
        valid_n = out_valid;

        if (!en_in) begin
            state_n = IDLE;
            data_n  = '0;
            index_n = '0;
            valid_n = 1'b0;
        end else if (start) begin
            state_n = RUN;
            vec_n   = v_in;
            data_n  = '0;
            index_n = '0;
            valid_n = 1'b1;
        end else if (state == RUN && out_valid && out_ready) begin
            if (out_last) begin
                data_n  = '0;
                index_n = '0;
            end else begin
                data_n  = out_data ^ step;
                index_n = out_index + 1'b1;
            end
        end
    end

    // NOTE: the vector store is small and must read as zero after reset, so it is reset with the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            vec       <= '0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state     <= state_n;
            vec       <= vec_n;
            out_data  <= data_n;
            out_index <= index_n;
            out_last  <= &index_n;
            out_valid <= valid_n;
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_sobol_multi_gen.sv
// Scoreboard bench for sobol_multi_gen (WIDTH=3, DIMS=2): expected points come from the
// closed-form Gray-code Sobol formula, pushed at start and popped on each accepted transfer.
module tb_sobol_multi_gen;

    localparam int W = 3;
    localparam int D = 2;
    localparam int N = 1 << W;

    typedef struct packed {
        logic [D*W-1:0] data;
        logic [W-1:0]   idx;
        logic           last;
    } point_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [D*W*W-1:0] v_in;
    logic             en_in;
    logic             start;
    logic             out_ready;
    logic             out_valid;
    logic [D*W-1:0]   out_data;
    logic [W-1:0]     out_index;
    logic             out_last;
    logic             busy;

    int     n_compared   = 0;
    int     n_mismatched = 0;
    point_t sb[$];

    logic [D*W*W-1:0] vec_a;
    logic [D*W*W-1:0] vec_b;

    sobol_multi_gen #(.WIDTH(W), .DIMS(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .v_in      (v_in),
        .en_in     (en_in),
        .start     (start),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [D*W*W-1:0] pack_v(input logic [W-1:0] a0, a1, a2, b0, b1, b2);
        return {b2, b1, b0, a2, a1, a0};
    endfunction

    // Point i is the XOR of the vectors selected by the set bits of gray(i).
    function automatic point_t model_point(input logic [D*W*W-1:0] v, input int i);
        point_t     p;
        logic [W-1:0] g;
        g = W'(i ^ (i >> 1));
        p.data = '0;
        for (int d = 0; d < D; d++)
            for (int k = 0; k < W; k++)
                if (g[k]) p.data[d*W +: W] = p.data[d*W +: W] ^ v[(d*W + k)*W +: W];
        p.idx  = W'(i);
        p.last = (i == N - 1);
        return p;
    endfunction

    task automatic push_points(input logic [D*W*W-1:0] v, input int n);
        for (int j = 0; j < n; j++) sb.push_back(model_point(v, j % N));
    endtask

    task automatic do_start(input logic [D*W*W-1:0] v, input logic rdy);
        en_in     = 1'b1;
        start     = 1'b1;
        v_in      = v;
        out_ready = rdy;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called on a negedge; drives out_ready and pops/compares on every accepted point.
    task automatic run_stream(input int n, input bit rnd, output int cycles);
        int             acc;
        logic           prev_hold;
        logic [D*W-1:0] prev_data;
        logic [W-1:0]   prev_idx;
        point_t         exp_p, got_p;
        acc       = 0;
        cycles    = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_idx  = '0;
        while (acc < n && cycles < 200) begin
            if (prev_hold) begin
                n_compared++;
                if ({out_data, out_index} !== {prev_data, prev_idx}) begin
                    n_mismatched++;
                    $display("FAIL hold: data=%h idx=%0d, required data=%h idx=%0d",
                             out_data, out_index, prev_data, prev_idx);
                end
            end
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                got_p = '{data: out_data, idx: out_index, last: out_last};
                n_compared++;
                if (sb.size() == 0) begin
                    n_mismatched++;
                    $display("FAIL extra_point: got data=%h idx=%0d with empty scoreboard",
                             out_data, out_index);
                end else begin
                    exp_p = sb.pop_front();
                    if (got_p !== exp_p) begin
                        n_mismatched++;
                        $display("FAIL point: data=%h idx=%0d last=%b, required data=%h idx=%0d last=%b",
                                 got_p.data, got_p.idx, got_p.last, exp_p.data, exp_p.idx, exp_p.last);
                    end
                end
                acc++;
            end
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            prev_idx  = out_index;
            cycles++;
            @(negedge clk);
        end
        if (acc < n) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL stream_timeout: accepted %0d, required %0d", acc, n);
        end
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        en_in     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        v_in      = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_compared++;
        if ({out_valid, out_data, out_index, out_last, busy} !== '0) begin
            n_mismatched++;
            $display("FAIL reset: valid=%b data=%h idx=%0d last=%b busy=%b, required all zero",
                     out_valid, out_data, out_index, out_last, busy);
        end
    endtask

    task automatic test_back_to_back;
        int cycles;
        do_start(vec_a, 1'b0);
        n_compared++;
        if (busy !== 1'b1) begin
            n_mismatched++;
            $display("FAIL busy_run: busy=%b, required 1", busy);
        end
        push_points(vec_a, N + 1);
        run_stream(N + 1, 1'b0, cycles);
        n_compared++;
        if (cycles !== N + 1) begin
            n_mismatched++;
            $display("FAIL no_bubble: took %0d cycles, required %0d", cycles, N + 1);
        end
    endtask

    task automatic test_backpressure;
        int cycles;
        do_start(vec_a, 1'b0);
        push_points(vec_a, N);
        run_stream(N, 1'b1, cycles);
    endtask

    task automatic test_restart;
        int cycles;
        do_start(vec_a, 1'b0);
        push_points(vec_a, 3);
        run_stream(3, 1'b0, cycles);
        do_start(vec_b, 1'b1);
        push_points(vec_b, 4);
        run_stream(4, 1'b0, cycles);
    endtask

    task automatic test_enable_drop;
        en_in     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        n_compared++;
        if ({out_valid, out_data, out_index, out_last, busy} !== '0) begin
            n_mismatched++;
            $display("FAIL en_drop: valid=%b data=%h idx=%0d last=%b busy=%b, required all zero",
                     out_valid, out_data, out_index, out_last, busy);
        end
        start = 1'b1;
        v_in  = vec_a;
        @(negedge clk);
        start = 1'b0;
        n_compared++;
        if ({out_valid, busy} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL start_while_disabled: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        en_in = 1'b1;
        @(negedge clk);
        n_compared++;
        if ({out_valid, busy} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL idle_after_enable: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_async_reset;
        do_start(vec_a, 1'b1);
        repeat (3) @(negedge clk);
        n_compared++;
        if ({out_valid, busy} !== 2'b11) begin
            n_mismatched++;
            $display("FAIL pre_reset_run: valid=%b busy=%b, required 1 1", out_valid, busy);
        end
        #2 rst = 1'b1;
        #1;
        n_compared++;
        if ({out_valid, out_data, out_index, out_last, busy} !== '0) begin
            n_mismatched++;
            $display("FAIL async_reset: valid=%b data=%h idx=%0d last=%b busy=%b, required all zero",
                     out_valid, out_data, out_index, out_last, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_compared++;
        if ({out_valid, busy} !== 2'b00) begin
            n_mismatched++;
            $display("FAIL idle_after_reset: valid=%b busy=%b, required 0 0", out_valid, busy);
        end
        do_start(vec_b, 1'b0);
        n_compared++;
        if ({out_valid, out_data, out_index} !== {1'b1, {(D*W){1'b0}}, {W{1'b0}}}) begin
            n_mismatched++;
            $display("FAIL start_after_reset: valid=%b data=%h idx=%0d, required 1 0 0",
                     out_valid, out_data, out_index);
        end
    endtask

    initial begin
        // dim0 V = 100,010,001; dim1 V = 100,110,101
        vec_a = pack_v(3'b100, 3'b010, 3'b001, 3'b100, 3'b110, 3'b101);
        // dim0 V = 001,010,100; dim1 unchanged
        vec_b = pack_v(3'b001, 3'b010, 3'b100, 3'b100, 3'b110, 3'b101);
        test_reset;
        test_back_to_back;
        test_backpressure;
        test_restart;
        test_enable_drop;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
